instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 141 ++++++++++++++
 tb/tb_instr_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: pairs of bytes (low, high) are assembled into
// 9-bit instruction words and written sequentially into instruction memory.
module instr_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [8:0]          data_q,  data_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                last_q,  last_d;
  logic                accept;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_MAX) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W:0] count_inc(input logic [ADDR_W:0] c);
    return c + (ADDR_W+1)'(1);
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOW;
          addr_d  = '0;
          count_d = '0;
          last_d  = 1'b0;
        end
      end
      S_LOW: begin
        // An odd-length program ends on a low byte; nothing is captured.
        if (accept) begin
          if (in_last) begin
            state_d = S_ERR;
          end else begin
            data_d[7:0] = in_data;
            state_d     = S_HIGH;
          end
        end
      end
      S_HIGH: begin
        if (accept) begin
          if (|in_data[7:1]) begin
            state_d = S_ERR;
          end else begin
            data_d[8] = in_data[0];
            last_d    = in_last;
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = count_inc(count_q);
        addr_d  = addr_inc(addr_q);
        // A final word that exactly fills memory is legal, so last wins.
        if (last_q) begin
          state_d = S_DONE;
        end else if (count_d == DEPTH_C) begin
          state_d = S_ERR;
        end else begin
          state_d = S_LOW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_LOW:   begin in_ready = 1'b1; busy = 1'b1; end
      S_HIGH:  begin in_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin wr_en    = 1'b1; busy = 1'b1; end
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: normal loads, stalls, format/length errors,
// full and overflowing memory, and reset during a write.
module tb_instr_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wlog_addr [0:511];
  logic [8:0]        wlog_data [0:511];
  int                wcnt = 0;

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Each WRITE state spans one full cycle, so one negedge sees each strobe.
  always @(negedge clk) begin
    if (wr_en === 1'b1 && wcnt < 512) begin
      wlog_addr[wcnt] = wr_addr;
      wlog_data[wcnt] = wr_data;
      wcnt = wcnt + 1;
    end
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    bit ok;
    tick(gap);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (!ok) begin
      $display("FAIL send_byte_timeout: byte %h not accepted in 20 cycles (required accepted)", d);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_checks++;
    if ({in_ready, wr_en, busy, done, error} !== 5'b0) begin
      $display("FAIL reset_ctrl: got %b required 00000", {in_ready, wr_en, busy, done, error});
      n_fail++;
    end
    n_checks++;
    if (wr_addr !== 8'd0 || wr_data !== 9'd0 || count !== 9'd0) begin
      $display("FAIL reset_data: addr=%h data=%h count=%0d required 0", wr_addr, wr_data, count);
      n_fail++;
    end
    reset = 1'b0;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL idle_after_reset: busy=%b in_ready=%b required 0", busy, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_single();
    logic [8:0] held;
    wcnt = 0;
    do_start();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL single_low: busy=%b in_ready=%b required 1", busy, in_ready);
      n_fail++;
    end
    send_byte(8'h0C, 1'b0, 0);
    send_byte(8'h01, 1'b1, 0);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 9'h10C) begin
      $display("FAIL single_write: wr_en=%b addr=%h data=%h required 1/00/10c", wr_en, wr_addr, wr_data);
      n_fail++;
    end
    tick(1);
    n_checks++;
    if (wr_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || count !== 9'd1) begin
      $display("FAIL single_done: wr_en=%b done=%b busy=%b count=%0d required 0/1/0/1", wr_en, done, busy, count);
      n_fail++;
    end
    held = wr_data;
    tick(3);
    n_checks++;
    if (done !== 1'b1 || wr_data !== 9'h10C || count !== 9'd1 || wr_addr !== 8'd1 || wcnt !== 1) begin
      $display("FAIL single_hold: done=%b data=%h count=%0d addr=%h writes=%0d required 1/10c/1/01/1",
               done, wr_data, count, wr_addr, wcnt);
      n_fail++;
    end
    n_checks++;
    if (held !== 9'h10C) begin
      $display("FAIL single_data: got %h required 10c", held);
      n_fail++;
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [0:5];
    int         gaps  [0:5];
    logic [8:0] exp   [0:2];
    bytes = '{8'hA5, 8'h01, 8'h3C, 8'h00, 8'hFF, 8'h01};
    gaps  = '{0, 2, 4, 1, 3, 0};
    exp   = '{9'h1A5, 9'h03C, 9'h1FF};
    wcnt = 0;
    do_start();
    n_checks++;
    if (done !== 1'b0 || count !== 9'd0 || wr_addr !== 8'd0) begin
      $display("FAIL gaps_clear: done=%b count=%0d addr=%h required 0/0/00", done, count, wr_addr);
      n_fail++;
    end
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], (i == 5), gaps[i]);
      if (i == 0) do_start(); // must be ignored while loading
    end
    tick(2);
    n_checks++;
    if (wcnt !== 3 || done !== 1'b1 || count !== 9'd3 || error !== 1'b0) begin
      $display("FAIL gaps_end: writes=%0d done=%b count=%0d error=%b required 3/1/3/0", wcnt, done, count, error);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wlog_addr[k] !== k[7:0] || wlog_data[k] !== exp[k]) begin
        $display("FAIL gaps_write%0d: addr=%h data=%h required %h/%h", k, wlog_addr[k], wlog_data[k], k[7:0], exp[k]);
        n_fail++;
      end
    end
  endtask

  task automatic test_format_err();
    wcnt = 0;
    do_start();
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    tick(2);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || count !== 9'd0 || done !== 1'b0 || wcnt !== 0) begin
      $display("FAIL format_err: error=%b busy=%b count=%0d done=%b writes=%0d required 1/0/0/0/0",
               error, busy, count, done, wcnt);
      n_fail++;
    end
  endtask

  task automatic test_odd_err();
    wcnt = 0;
    do_start();
    n_checks++;
    if (error !== 1'b0) begin
      $display("FAIL odd_clear: error=%b required 0", error);
      n_fail++;
    end
    send_byte(8'h12, 1'b1, 0);
    tick(2);
    n_checks++;
    if (error !== 1'b1 || wcnt !== 0 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL odd_err: error=%b writes=%0d wr_en=%b in_ready=%b required 1/0/0/0", error, wcnt, wr_en, in_ready);
      n_fail++;
    end
  endtask

  task automatic load_n(input int n, input bit last_on_n);
    logic [8:0] w;
    for (int k = 0; k < n; k++) begin
      w = {k[0], k[7:0]};
      send_byte(w[7:0], 1'b0, 0);
      send_byte({7'b0, w[8]}, last_on_n && (k == n - 1), 0);
    end
  endtask

  task automatic test_full();
    int bad;
    wcnt = 0;
    do_start();
    load_n(256, 1'b1);
    tick(2);
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || count !== 9'd256 || wr_addr !== 8'd0 || wcnt !== 256) begin
      $display("FAIL full_end: done=%b error=%b count=%0d addr=%h writes=%0d required 1/0/256/00/256",
               done, error, count, wr_addr, wcnt);
      n_fail++;
    end
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (wlog_addr[k] !== k[7:0] || wlog_data[k] !== {k[0], k[7:0]}) bad++;
    n_checks++;
    if (bad !== 0) begin
      $display("FAIL full_data: %0d bad writes required 0", bad);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    wcnt = 0;
    do_start();
    load_n(256, 1'b0);
    // 257th word offered but the loader must refuse it
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick(2);
    n_checks++;
    if (error !== 1'b1 || done !== 1'b0 || count !== 9'd256 || wcnt !== 256 || in_ready !== 1'b0) begin
      $display("FAIL overflow: error=%b done=%b count=%0d writes=%0d in_ready=%b required 1/0/256/256/0",
               error, done, count, wcnt, in_ready);
      n_fail++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    wcnt = 0;
    do_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 8'd1 || wr_data !== 9'h122) begin
      $display("FAIL rst_write_cycle: wr_en=%b addr=%h data=%h required 1/01/122", wr_en, wr_addr, wr_data);
      n_fail++;
    end
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({in_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== 8'd0 || wr_data !== 9'd0 || count !== 9'd0) begin
      $display("FAIL rst_mid_write: ctrl=%b addr=%h data=%h count=%0d required all 0",
               {in_ready, wr_en, busy, done, error}, wr_addr, wr_data, count);
      n_fail++;
    end
    tick(1);
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL rst_stays_idle: busy=%b required 0", busy);
      n_fail++;
    end
    do_start();
    send_byte(8'h07, 1'b0, 1);
    send_byte(8'h01, 1'b1, 0);
    tick(2);
    n_checks++;
    if (wcnt !== 3 || wlog_addr[2] !== 8'd0 || wlog_data[2] !== 9'h107 || done !== 1'b1 || count !== 9'd1) begin
      $display("FAIL reload: writes=%0d addr=%h data=%h done=%b count=%0d required 3/00/107/1/1",
               wcnt, wlog_addr[2], wlog_data[2], done, count);
      n_fail++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_gaps();
    test_format_err();
    test_odd_err();
    test_full();
    test_overflow();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
